pmem_burst_adaptor: RTL

Responder for the cache-side physical memory interface. Accepts whole-line read and write requests from the data cache: 256-bit line, 32-bit address, read/write/resp handshake. Converts each request into a fixed-length burst of 64-bit beats on the main-memory port, and returns a single-cycle response once the whole line has moved. Sits between the dcache (or cache arbiter) and physical memory.

---
 rtl/pmem_burst_pkg.sv | 25 ++
 rtl/pmem_burst_adaptor.sv | 97 +++++++++
 2 files changed

// File: rtl/pmem_burst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_burst_pkg
//  Description : Shared constants and state encoding for the cache-line to
//                memory-burst adaptor.
//  Revision    : 1.0  initial release
// ============================================================================
package pmem_burst_pkg;

   // Line offset bits; a line is 2**S_OFFSET bytes
   localparam int S_OFFSET  = 5;
   localparam int S_LINE    = 8 * (2 ** S_OFFSET);
   localparam int S_BURST   = 64;
   localparam int NUM_BEATS = S_LINE / S_BURST;
   localparam int BEAT_W    = $clog2(NUM_BEATS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pmem_burst_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_burst_adaptor
//  Description : Accepts whole-line read/write requests from the cache and
//                moves each line as a fixed burst of beats on the memory
//                port, returning a single-cycle completion pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module pmem_burst_adaptor
   import pmem_burst_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   // cache side
   input  logic [31:0]         pmem_address,
   input  logic                pmem_read,
   input  logic                pmem_write,
   input  logic [S_LINE-1:0]   pmem_wdata,
   output logic [S_LINE-1:0]   pmem_rdata,
   output logic                pmem_resp,
   // memory side
   output logic [31:0]         mem_address,
   output logic                mem_read,
   output logic                mem_write,
   output logic [S_BURST-1:0]  mem_wdata,
   input  logic [S_BURST-1:0]  mem_rdata,
   input  logic                mem_resp
);

   // Clears the byte-within-line bits of the incoming address
   localparam logic [31:0] c_line_mask = ~((32'd1 << S_OFFSET) - 32'd1);

   state_t              r_state;
   state_t              w_next_state;
   logic [BEAT_W-1:0]   r_count;
   logic [31:0]         r_addr;
   logic [S_LINE-1:0]   r_wbuf;
   logic [S_LINE-1:0]   r_rline;
   logic                w_accept;
   logic                w_in_burst;
   logic                w_last_beat;

   // Requests are only taken in IDLE; anything seen elsewhere is ignored
   assign w_accept    = (r_state == ST_IDLE) && (pmem_read || pmem_write);
   assign w_in_burst  = (r_state == ST_READ) || (r_state == ST_WRITE);
   assign w_last_beat = mem_resp && (r_count == BEAT_W'(NUM_BEATS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state decode; a simultaneous read+write request resolves to WRITE
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (pmem_write)     w_next_state = ST_WRITE;
            else if (pmem_read) w_next_state = ST_READ;
         end
         ST_READ:  if (w_last_beat) w_next_state = ST_DONE;
         ST_WRITE: if (w_last_beat) w_next_state = ST_DONE;
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Request capture, beat counting and read-line assembly
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_wbuf  <= '0;
         r_rline <= '0;
         r_count <= '0;
      end else if (w_accept) begin
         r_addr  <= pmem_address & c_line_mask;
         r_wbuf  <= pmem_wdata;
         r_count <= '0;
      end else if (w_in_burst && mem_resp) begin
         if (r_state == ST_READ)
            r_rline[32'(r_count) * S_BURST +: S_BURST] <= mem_rdata;
         r_count <= r_count + BEAT_W'(1);
      end
   end

   assign mem_address = r_addr;
   assign mem_read    = (r_state == ST_READ);
   assign mem_write   = (r_state == ST_WRITE);
   assign pmem_resp   = (r_state == ST_DONE);
   assign pmem_rdata  = r_rline;
   // Current write beat is presented only while a write burst is active
   assign mem_wdata   = (r_state == ST_WRITE) ?
                        r_wbuf[32'(r_count) * S_BURST +: S_BURST] : '0;

endmodule
`default_nettype wire
